csi_packet_decoder: RTL and testbench

Packet-layer decoder for the two-lane MIPI CSI-2 receive path. It sits directly downstream of the lane byte aligner and consumes its 32-bit aligned word stream, one HS burst at a time. It validates the packet header ECC, decodes Frame Start and Frame End short packets, and unpacks RAW8 long-packet payloads into 4-pixel words with line and frame markers for the downstream pixel/Bayer stage. The 2-byte CRC footer is consumed and discarded; CRC checking is out of scope.

---
 rtl/csi_pkg.sv | 41 ++++
 rtl/csi_header_ecc.sv | 24 ++
 rtl/csi_packet_decoder.sv | 135 +++++++++++++
 tb/tb_csi_packet_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 packet definitions: data types, decoder states, header layout.
package csi_pkg;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  localparam int HDR_DT_LSB  = 0;
  localparam int HDR_VC_LSB  = 6;
  localparam int HDR_WC_LSB  = 8;
  localparam int HDR_ECC_LSB = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Field order matches the wire: DI in [7:0], WC in [23:8], ECC in [31:24].
  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } hdr_t;

  function automatic logic [3:0] keep_for(input logic [1:0] n);
    case (n)
      2'd1:    return 4'h1;
      2'd2:    return 4'h3;
      2'd3:    return 4'h7;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] keep);
    return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
  endfunction

endpackage

// File: rtl/csi_header_ecc.sv
// CSI-2 packet header Hamming ECC generator over the 24 DI/WC bits.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module csi_header_ecc (
  input  logic [23:0] hdr,
  output logic [5:0]  ecc
);

  // Each mask selects the header bits covered by one parity bit.
  localparam logic [23:0] P0_MASK = 24'hF12CB7;
  localparam logic [23:0] P1_MASK = 24'hF2555B;
  localparam logic [23:0] P2_MASK = 24'h749A6D;
  localparam logic [23:0] P3_MASK = 24'hB8E38E;
  localparam logic [23:0] P4_MASK = 24'hDF03F0;
  localparam logic [23:0] P5_MASK = 24'hEFFC00;

  assign ecc[0] = ^(hdr & P0_MASK);
  assign ecc[1] = ^(hdr & P1_MASK);
  assign ecc[2] = ^(hdr & P2_MASK);
  assign ecc[3] = ^(hdr & P3_MASK);
  assign ecc[4] = ^(hdr & P4_MASK);
  assign ecc[5] = ^(hdr & P5_MASK);

endmodule

// File: rtl/csi_packet_decoder.sv
// CSI-2 packet decoder: header ECC check, FS/FE decode, RAW8 payload to 4-pixel words.
// Latency: all outputs one cycle after the accepting word_valid edge.
// Backpressure: none; the pixel consumer must take every pix_valid.
module csi_packet_decoder
  import csi_pkg::*;
#(
  parameter int LINE_W = 12,
  parameter int WC_W   = 16
) (
  input  logic              mipi_clk,
  input  logic              reset,
  input  logic              stop,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic [31:0]       pix_data,
  output logic [3:0]        pix_keep,
  output logic              pix_valid,
  output logic              line_start,
  output logic              line_end,
  output logic              frame_start,
  output logic              frame_end,
  output logic [LINE_W-1:0] line_count,
  output logic [1:0]        virt_ch,
  output logic              hdr_err,
  output logic              trunc_err
);

  hdr_t            hdr;
  logic [5:0]      ecc_calc;
  logic            ecc_ok;
  state_t          state;
  logic [WC_W-1:0] remaining;
  logic [WC_W-1:0] take;
  logic [3:0]      keep_next;
  logic            emitted;

  assign hdr = hdr_t'(word_in);

  csi_header_ecc u_ecc (
    .hdr (word_in[HDR_ECC_LSB-1:0]),
    .ecc (ecc_calc)
  );

  assign ecc_ok = (hdr.ecc == {2'b00, ecc_calc});

  always_comb begin
    take      = remaining;
    keep_next = keep_for(remaining[1:0]);
    if (remaining >= WC_W'(4)) begin
      take      = WC_W'(4);
      keep_next = 4'hF;
    end
  end

  always_ff @(posedge mipi_clk) begin
    if (!reset) begin
      state       <= IDLE;
      remaining   <= '0;
      emitted     <= 1'b0;
      pix_data    <= '0;
      pix_keep    <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_count  <= '0;
      virt_ch     <= '0;
      hdr_err     <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      pix_keep    <= '0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      hdr_err     <= 1'b0;
      trunc_err   <= 1'b0;

      // The line counter advances the cycle after line_end is seen.
      if (line_end) line_count <= line_count + LINE_W'(1);

      if (stop) begin
        if (state == PAYLOAD && emitted) trunc_err <= 1'b1;
        state   <= IDLE;
        emitted <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= HEADER;
            emitted <= 1'b0;
          end
          HEADER: begin
            if (word_valid) begin
              state <= DONE;
              if (!ecc_ok) begin
                hdr_err <= 1'b1;
              end else begin
                virt_ch <= hdr.vc;
                if (hdr.dt == DT_FS) begin
                  frame_start <= 1'b1;
                  line_count  <= '0;
                end else if (hdr.dt == DT_FE) begin
                  frame_end <= 1'b1;
                end else if (hdr.dt == DT_RAW8 && hdr.wc != '0) begin
                  remaining <= WC_W'(hdr.wc);
                  state     <= PAYLOAD;
                end
              end
            end
          end
          PAYLOAD: begin
            if (word_valid) begin
              pix_valid  <= 1'b1;
              pix_keep   <= keep_next;
              pix_data   <= word_in & byte_mask(keep_next);
              line_start <= !emitted;
              emitted    <= 1'b1;
              remaining  <= remaining - take;
              if (remaining == take) begin
                line_end <= 1'b1;
                state    <= DONE;
              end
            end
          end
          default: begin
            state <= DONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi_packet_decoder.sv
// Directed bench for csi_packet_decoder with hand-computed expectations.
module tb_csi_packet_decoder;

  logic        mipi_clk;
  logic        reset;
  logic        stop;
  logic [31:0] word_in;
  logic        word_valid;
  logic [31:0] pix_data;
  logic [3:0]  pix_keep;
  logic        pix_valid;
  logic        line_start;
  logic        line_end;
  logic        frame_start;
  logic        frame_end;
  logic [11:0] line_count;
  logic [1:0]  virt_ch;
  logic        hdr_err;
  logic        trunc_err;

  int total;
  int passed;
  int nvalid;
  int nend;

  csi_packet_decoder dut (
    .mipi_clk    (mipi_clk),
    .reset       (reset),
    .stop        (stop),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .pix_data    (pix_data),
    .pix_keep    (pix_keep),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .line_end    (line_end),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_count  (line_count),
    .virt_ch     (virt_ch),
    .hdr_err     (hdr_err),
    .trunc_err   (trunc_err)
  );

  initial begin
    mipi_clk = 1'b0;
    forever #5 mipi_clk = ~mipi_clk;
  end

  // {pix_valid, line_start, line_end, frame_start, frame_end, hdr_err, trunc_err}
  function automatic logic [31:0] pulses();
    return {25'd0, pix_valid, line_start, line_end, frame_start, frame_end, hdr_err, trunc_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply inputs for one clock; returns at the following negedge.
  task automatic cyc(input logic s, input logic v, input logic [31:0] w);
    stop       = s;
    word_valid = v;
    word_in    = w;
    @(negedge mipi_clk);
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b0;
    stop = 1'b1;
    word_valid = 1'b0;
    word_in = '0;
    @(negedge mipi_clk);
    cyc(1'b1, 1'b0, 32'h0);
    chk("reset_pulses", pulses(), 32'h0);
    chk("reset_data", pix_data, 32'h0);
    chk("reset_keep", {28'd0, pix_keep}, 32'h0);
    chk("reset_linecnt", {20'd0, line_count}, 32'h0);
    chk("reset_vc", {30'd0, virt_ch}, 32'h0);

    // Frame Start
    reset = 1'b1;
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h00000000);
    chk("fs_pulse", pulses(), 32'b0001000);
    chk("fs_linecnt", {20'd0, line_count}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("fs_pulse_width", pulses(), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);

    // RAW8 WC=4, sparse valid
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h3300042A);
    chk("wc4_hdr_quiet", pulses(), 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h44332211);
    chk("wc4_pulses", pulses(), 32'b1110000);
    chk("wc4_data", pix_data, 32'h44332211);
    chk("wc4_keep", {28'd0, pix_keep}, 32'hF);
    chk("wc4_linecnt_hold", {20'd0, line_count}, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000BEEF);
    chk("wc4_crc_quiet", pulses(), 32'h0);
    chk("wc4_linecnt_inc", {20'd0, line_count}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0);

    // RAW8 WC=6, back-to-back valid
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h2F00062A);
    cyc(1'b0, 1'b1, 32'h44332211);
    chk("wc6_first", pulses(), 32'b1100000);
    chk("wc6_first_keep", {28'd0, pix_keep}, 32'hF);
    cyc(1'b0, 1'b1, 32'hCCBB6655);
    chk("wc6_second", pulses(), 32'b1010000);
    chk("wc6_second_keep", {28'd0, pix_keep}, 32'h3);
    chk("wc6_second_data", {16'd0, pix_data[15:0]}, 32'h6655);
    chk("wc6_linecnt_hold", {20'd0, line_count}, 32'h1);
    cyc(1'b0, 1'b1, 32'h00001234);
    chk("wc6_no_third", pulses(), 32'h0);
    chk("wc6_linecnt_inc", {20'd0, line_count}, 32'h2);
    cyc(1'b1, 1'b0, 32'h0);

    // Corrupted ECC
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0F02802A);
    chk("ecc_hdr_err", pulses(), 32'b0000010);
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 32'h11111111 * (i + 1));
      if (pix_valid) nvalid++;
    end
    chk("ecc_no_pixels", nvalid, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);

    // WC=640, truncated after 10 payload words
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0E02802A);
    chk("trunc_hdr_quiet", pulses(), 32'h0);
    nvalid = 0;
    nend = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 32'hA0000000 + i);
      if (pix_valid) nvalid++;
      if (line_end) nend++;
      chk("trunc_word", pulses(), (i == 0) ? 32'b1100000 : 32'b1000000);
    end
    chk("trunc_count", nvalid, 32'd10);
    chk("trunc_no_end", nend, 32'd0);
    cyc(1'b1, 1'b1, 32'hDEADBEEF);
    chk("trunc_err_pulse", pulses(), 32'b0000001);
    chk("trunc_linecnt", {20'd0, line_count}, 32'h2);
    cyc(1'b1, 1'b0, 32'h0);
    chk("trunc_err_width", pulses(), 32'h0);

    // Frame End, VC=0 then VC=1
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h07000001);
    chk("fe_pulse", pulses(), 32'b0000100);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h11000041);
    chk("fe_vc1_pulse", pulses(), 32'b0000100);
    chk("fe_vc1", {30'd0, virt_ch}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0);

    // Reset in the middle of a payload
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0E02802A);
    cyc(1'b0, 1'b1, 32'h55555555);
    chk("rst_pre_pixel", pulses(), 32'b1100000);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 32'h66666666);
    chk("rst_pulses", pulses(), 32'h0);
    chk("rst_data", pix_data, 32'h0);
    chk("rst_keep", {28'd0, pix_keep}, 32'h0);
    chk("rst_linecnt", {20'd0, line_count}, 32'h0);
    chk("rst_vc", {30'd0, virt_ch}, 32'h0);
    // From IDLE the first valid word is ignored, the next is the header.
    reset = 1'b1;
    cyc(1'b0, 1'b1, 32'h00000000);
    chk("rst_idle_ignores", pulses(), 32'h0);
    cyc(1'b0, 1'b1, 32'h07000001);
    chk("rst_then_header", pulses(), 32'b0000100);
    cyc(1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
